// File: rtl/wb_trace_buffer.sv
// Register-file writeback trace FIFO with trigger/post-count freeze and a
// valid/ready drain port; the head entry is presented from a registered copy.
module wb_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 6,
    parameter int unsigned PC_W   = 6,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_we,
    input  logic [REG_W-1:0]       wb_rd,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic [PC_W-1:0]        wb_pc,
    input  logic                   capture_en,
    input  logic                   wrap_mode,
    input  logic                   trig_en,
    input  logic [REG_W-1:0]       trig_rd,
    input  logic [CNT_W-1:0]       post_cnt,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [DATA_W-1:0]      trace_data,
    output logic [REG_W-1:0]       trace_rd,
    output logic [PC_W-1:0]        trace_pc,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   frozen
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = PC_W + REG_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [ENT_W-1:0]   head_q, head_d;
    logic               valid_q, valid_d;
    logic               full_q, full_d;
    logic               frozen_q, frozen_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic               push, pop, is_full, do_write, do_drop;
    logic [ENT_W-1:0]   new_entry;

    // FIFO bookkeeping: level tracks push/pop, never pointer difference
    always_comb begin
        new_entry = {wb_pc, wb_rd, wb_data};
        push      = wb_we && (state_q == ST_RUN || state_q == ST_POST);
        pop       = valid_q && trace_ready;
        is_full   = (level_q == LVL_W'(DEPTH));
        do_write  = push && (!is_full || pop || wrap_mode);
        do_drop   = push && is_full && !pop;
        wr_d      = wr_q;
        rd_d      = rd_q;
        level_d   = level_q;
        drop_d    = drop_q;
        head_d    = head_q;

        if (do_write) wr_d = wr_q + PTR_W'(1);
        if (pop || (do_drop && wrap_mode)) rd_d = rd_q + PTR_W'(1);
        if (push && !pop && !is_full) level_d = level_q + LVL_W'(1);
        else if (pop && !push)        level_d = level_q - LVL_W'(1);
        if (do_drop && drop_q != '1) drop_d = drop_q + CNT_W'(1);

        // New head bypasses the array when it lands on the next read slot
        if (do_write && wr_q == rd_d)  head_d = new_entry;
        else if (level_d != '0)        head_d = mem_q[rd_d];

        valid_d = (level_d != '0);
        full_d  = (level_d == LVL_W'(DEPTH));
    end

    // Capture FSM; capture_en low overrides every other transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (capture_en) state_d = ST_RUN;
            ST_RUN: begin
                if (push && trig_en && wb_rd == trig_rd) begin
                    if (post_cnt == '0) begin
                        state_d = ST_FROZEN;
                    end else begin
                        cnt_d   = post_cnt;
                        state_d = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (push) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
        endcase
        if (!capture_en && state_q != ST_IDLE) state_d = ST_IDLE;
        frozen_d = (state_d == ST_FROZEN);
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            frozen_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            frozen_q <= frozen_d;
        end
    end

    // Trace storage carries no reset
    always_ff @(posedge clk) begin
        if (rst && do_write) mem_q[wr_q] <= new_entry;
    end

    assign trace_valid = valid_q;
    assign trace_data  = head_q[DATA_W-1:0];
    assign trace_rd    = head_q[DATA_W +: REG_W];
    assign trace_pc    = head_q[DATA_W+REG_W +: PC_W];
    assign level       = level_q;
    assign full        = full_q;
    assign drop_cnt    = drop_q;
    assign frozen      = frozen_q;

endmodule
